// File: rtl/swg_window_maxpool_if.sv
// Valid/ready/data stream channel used on both sides of swg_window_maxpool.
// DATA_W must equal BIT_WIDTH*SIMD of the attached reducer.
interface swg_window_maxpool_if #(
  parameter int DATA_W = 4
);
  logic              tvalid;
  logic              tready;
  logic [DATA_W-1:0] tdata;

  modport master (output tvalid, output tdata, input tready);
  modport slave  (input tvalid, input tdata, output tready);
endinterface

// File: rtl/swg_window_maxpool.sv
// Streaming per-lane max-pool reducer behind a sliding-window generator (kernel outer, channel fold inner).
// Build macro SWG_MAXPOOL_PERF_CNT_EN adds the 32-bit win_count completed-window counter port.
module swg_window_maxpool #(
  parameter int BIT_WIDTH    = 4,
  parameter int SIMD         = 1,
  parameter int KERNEL_ELEMS = 4,
  parameter int CHAN_FOLD    = 1,
  parameter int SIGNED       = 0
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst_n,
  swg_window_maxpool_if.slave  in0_V_V,
  swg_window_maxpool_if.master out_V_V
`ifdef SWG_MAXPOOL_PERF_CNT_EN
  ,
  output logic [31:0]          win_count
`endif
);
  localparam int DW = BIT_WIDTH * SIMD;
  localparam int KW = (KERNEL_ELEMS > 1) ? $clog2(KERNEL_ELEMS) : 1;
  localparam int CW = (CHAN_FOLD > 1) ? $clog2(CHAN_FOLD) : 1;
  localparam logic [KW-1:0] K_LAST  = KW'(KERNEL_ELEMS - 1);
  localparam logic [CW-1:0] CF_LAST = CW'(CHAN_FOLD - 1);

  function automatic logic lane_gt(input logic [BIT_WIDTH-1:0] a, input logic [BIT_WIDTH-1:0] b);
    logic gt;
    if (SIGNED != 0) begin
      gt = ($signed(a) > $signed(b));
    end else begin
      gt = (a > b);
    end
    return gt;
  endfunction

  // Ties keep the accumulator lane.
  function automatic logic [DW-1:0] lane_max(input logic [DW-1:0] acc, input logic [DW-1:0] din);
    logic [DW-1:0] res;
    res = acc;
    for (int i = 0; i < SIMD; i++) begin
      if (lane_gt(din[i*BIT_WIDTH +: BIT_WIDTH], acc[i*BIT_WIDTH +: BIT_WIDTH])) begin
        res[i*BIT_WIDTH +: BIT_WIDTH] = din[i*BIT_WIDTH +: BIT_WIDTH];
      end else begin
        res[i*BIT_WIDTH +: BIT_WIDTH] = acc[i*BIT_WIDTH +: BIT_WIDTH];
      end
    end
    return res;
  endfunction

  logic [KW-1:0] k_cnt_r;
  logic [CW-1:0] cf_cnt_r;
  logic [DW-1:0] acc_mem_r [CHAN_FOLD];
  logic          out_valid_r;
  logic [DW-1:0] out_data_r;

  logic          k_first_s;
  logic          k_last_s;
  logic          cf_last_s;
  logic          tready_s;
  logic          in_ok_s;
  logic          out_ok_s;
  logic [DW-1:0] acc_rd_s;
  logic [DW-1:0] merged_s;

  // Handshake decode and merge of the stored partial max with the incoming beat.
  always_comb begin
    k_first_s = (k_cnt_r == {KW{1'b0}});
    k_last_s  = (k_cnt_r == K_LAST);
    cf_last_s = (cf_cnt_r == CF_LAST);
    tready_s  = ap_rst_n & (~k_last_s | ~out_valid_r | out_V_V.tready);
    in_ok_s   = in0_V_V.tvalid & tready_s;
    out_ok_s  = out_valid_r & out_V_V.tready;
    acc_rd_s  = acc_mem_r[cf_cnt_r];
    if (k_first_s) begin
      merged_s = in0_V_V.tdata;
    end else begin
      merged_s = lane_max(acc_rd_s, in0_V_V.tdata);
    end
  end

  assign in0_V_V.tready = tready_s;
  assign out_V_V.tvalid = out_valid_r;
  assign out_V_V.tdata  = out_data_r;

  // Fold counter runs innermost; kernel counter advances when the fold counter wraps.
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      k_cnt_r  <= {KW{1'b0}};
      cf_cnt_r <= {CW{1'b0}};
    end else if (in_ok_s) begin
      if (cf_last_s) begin
        cf_cnt_r <= {CW{1'b0}};
        if (k_last_s) begin
          k_cnt_r <= {KW{1'b0}};
        end else begin
          k_cnt_r <= k_cnt_r + KW'(1'b1);
        end
      end else begin
        cf_cnt_r <= cf_cnt_r + CW'(1'b1);
        k_cnt_r  <= k_cnt_r;
      end
    end else begin
      k_cnt_r  <= k_cnt_r;
      cf_cnt_r <= cf_cnt_r;
    end
  end

  // Partial-max memory; the final kernel position bypasses it straight into the output register.
  always_ff @(posedge ap_clk) begin
    if (in_ok_s && !k_last_s) begin
      acc_mem_r[cf_cnt_r] <= merged_s;
    end
  end

  // Single output slot: a new final beat may replace a value being consumed in the same cycle.
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      out_valid_r <= 1'b0;
      out_data_r  <= {DW{1'b0}};
    end else if (in_ok_s && k_last_s) begin
      out_valid_r <= 1'b1;
      out_data_r  <= merged_s;
    end else if (out_ok_s) begin
      out_valid_r <= 1'b0;
      out_data_r  <= out_data_r;
    end else begin
      out_valid_r <= out_valid_r;
      out_data_r  <= out_data_r;
    end
  end

`ifdef SWG_MAXPOOL_PERF_CNT_EN
  logic        out_last_fold_r;
  logic [31:0] win_count_r;

  // Counts windows whose last-fold result has been taken downstream.
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      out_last_fold_r <= 1'b0;
      win_count_r     <= 32'd0;
    end else begin
      if (in_ok_s && k_last_s) begin
        out_last_fold_r <= cf_last_s;
      end else begin
        out_last_fold_r <= out_last_fold_r;
      end
      if (out_ok_s && out_last_fold_r) begin
        win_count_r <= win_count_r + 32'd1;
      end else begin
        win_count_r <= win_count_r;
      end
    end
  end

  assign win_count = win_count_r;
`endif

endmodule

// File: tb/tb_swg_window_maxpool.sv
// Randomised bench for swg_window_maxpool: three instances (unsigned, signed, SIMD2/fold2) against a window-level max model.
module tb_swg_window_maxpool;
  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  logic       ab_vld, a_rdy, c_vld, c_rdy;
  logic [3:0] ab_dat;
  logic [7:0] c_dat;
  bit         rnd_done;
  int         t0, g0;

  swg_window_maxpool_if #(.DATA_W(4)) a_in (), a_out (), b_in (), b_out ();
  swg_window_maxpool_if #(.DATA_W(8)) c_in (), c_out ();

  assign a_in.tvalid  = ab_vld;
  assign a_in.tdata   = ab_dat;
  assign b_in.tvalid  = ab_vld;
  assign b_in.tdata   = ab_dat;
  assign a_out.tready = a_rdy;
  assign b_out.tready = a_rdy;
  assign c_in.tvalid  = c_vld;
  assign c_in.tdata   = c_dat;
  assign c_out.tready = c_rdy;

`ifdef SWG_MAXPOOL_PERF_CNT_EN
  logic [31:0] a_wc, b_wc, c_wc;
`endif

  swg_window_maxpool #(.BIT_WIDTH(4), .SIMD(1), .KERNEL_ELEMS(4), .CHAN_FOLD(1), .SIGNED(0)) dut_a (
    .ap_clk(clk), .ap_rst_n(rst_n), .in0_V_V(a_in), .out_V_V(a_out)
`ifdef SWG_MAXPOOL_PERF_CNT_EN
    , .win_count(a_wc)
`endif
  );
  swg_window_maxpool #(.BIT_WIDTH(4), .SIMD(1), .KERNEL_ELEMS(4), .CHAN_FOLD(1), .SIGNED(1)) dut_b (
    .ap_clk(clk), .ap_rst_n(rst_n), .in0_V_V(b_in), .out_V_V(b_out)
`ifdef SWG_MAXPOOL_PERF_CNT_EN
    , .win_count(b_wc)
`endif
  );
  swg_window_maxpool #(.BIT_WIDTH(4), .SIMD(2), .KERNEL_ELEMS(2), .CHAN_FOLD(2), .SIGNED(0)) dut_c (
    .ap_clk(clk), .ap_rst_n(rst_n), .in0_V_V(c_in), .out_V_V(c_out)
`ifdef SWG_MAXPOOL_PERF_CNT_EN
    , .win_count(c_wc)
`endif
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int lane_val(input logic [63:0] w, input int l, input int bw, input bit sgn);
    int v;
    v = int'((w >> (l * bw)) & ((64'd1 << bw) - 64'd1));
    if (sgn && v >= (1 << (bw - 1))) v = v - (1 << bw);
    return v;
  endfunction

  // Max over all kernel positions of fold f; window beats are stored in arrival order.
  function automatic logic [63:0] ref_fold(input logic [63:0] win[$], input int f, input int k_n,
                                           input int cf_n, input int simd, input int bw, input bit sgn);
    logic [63:0] res;
    res = 64'd0;
    for (int l = 0; l < simd; l++) begin
      int best;
      best = lane_val(win[f], l, bw, sgn);
      for (int k = 1; k < k_n; k++) begin
        int v;
        v = lane_val(win[k * cf_n + f], l, bw, sgn);
        if (v > best) best = v;
      end
      res = res | ((64'(best) & ((64'd1 << bw) - 64'd1)) << (l * bw));
    end
    return res;
  endfunction

  logic [63:0] a_win[$], a_exp[$], b_win[$], b_exp[$], c_win[$], c_exp[$];
  int          a_got = 0, c_got = 0;
  bit          a_stall = 1'b0, a_fin = 1'b0, b_stall = 1'b0, c_stall = 1'b0, c_fin = 1'b0;
  logic [63:0] a_hold, b_hold, c_hold;

  // Scoreboard A (K=4, CF=1, unsigned).
  always @(negedge clk) begin
    if (!rst_n) begin
      check_eq("a_rst_tready", 64'(a_in.tready), 64'd0);
      a_win.delete(); a_exp.delete(); a_got = 0; a_stall = 1'b0; a_fin = 1'b0;
    end else begin
`ifdef SWG_MAXPOOL_PERF_CNT_EN
      check_eq("a_win_count", 64'(a_wc), 64'(a_got));
`endif
      if (a_fin) check_eq("a_latency", 64'(a_out.tvalid), 64'd1);
      if (a_stall) begin
        check_eq("a_hold_valid", 64'(a_out.tvalid), 64'd1);
        check_eq("a_hold_data", 64'(a_out.tdata), a_hold);
      end
      if (a_out.tvalid && a_out.tready) begin
        if (a_exp.size() == 0) check_eq("a_unexpected_out", 64'(a_exp.size()), 64'd1);
        else begin check_eq("a_data", 64'(a_out.tdata), a_exp.pop_front()); a_got++; end
      end
      a_stall = a_out.tvalid && !a_out.tready;
      a_hold  = 64'(a_out.tdata);
      a_fin   = 1'b0;
      if (a_in.tvalid && a_in.tready) begin
        a_win.push_back(64'(a_in.tdata));
        if (a_win.size() > 3) begin
          a_fin = 1'b1;
          a_exp.push_back(ref_fold(a_win, a_win.size() - 4, 4, 1, 1, 4, 1'b0));
        end
        if (a_win.size() == 4) a_win.delete();
      end
    end
  end

  // Scoreboard B (K=4, CF=1, signed).
  always @(negedge clk) begin
    if (!rst_n) begin
      b_win.delete(); b_exp.delete(); b_stall = 1'b0;
    end else begin
      if (b_stall) check_eq("b_hold_data", 64'(b_out.tdata), b_hold);
      if (b_out.tvalid && b_out.tready) begin
        if (b_exp.size() == 0) check_eq("b_unexpected_out", 64'(b_exp.size()), 64'd1);
        else check_eq("b_data", 64'(b_out.tdata), b_exp.pop_front());
      end
      b_stall = b_out.tvalid && !b_out.tready;
      b_hold  = 64'(b_out.tdata);
      if (b_in.tvalid && b_in.tready) begin
        b_win.push_back(64'(b_in.tdata));
        if (b_win.size() > 3) b_exp.push_back(ref_fold(b_win, b_win.size() - 4, 4, 1, 1, 4, 1'b1));
        if (b_win.size() == 4) b_win.delete();
      end
    end
  end

  // Scoreboard C (SIMD=2, K=2, CF=2, unsigned).
  always @(negedge clk) begin
    if (!rst_n) begin
      check_eq("c_rst_tready", 64'(c_in.tready), 64'd0);
      c_win.delete(); c_exp.delete(); c_got = 0; c_stall = 1'b0; c_fin = 1'b0;
    end else begin
`ifdef SWG_MAXPOOL_PERF_CNT_EN
      check_eq("c_win_count", 64'(c_wc), 64'(c_got / 2));
`endif
      if (c_fin) check_eq("c_latency", 64'(c_out.tvalid), 64'd1);
      if (c_stall) begin
        check_eq("c_hold_valid", 64'(c_out.tvalid), 64'd1);
        check_eq("c_hold_data", 64'(c_out.tdata), c_hold);
      end
      if (c_out.tvalid && c_out.tready) begin
        if (c_exp.size() == 0) check_eq("c_unexpected_out", 64'(c_exp.size()), 64'd1);
        else begin check_eq("c_data", 64'(c_out.tdata), c_exp.pop_front()); c_got++; end
      end
      c_stall = c_out.tvalid && !c_out.tready;
      c_hold  = 64'(c_out.tdata);
      c_fin   = 1'b0;
      if (c_in.tvalid && c_in.tready) begin
        c_win.push_back(64'(c_in.tdata));
        if (c_win.size() > 2) begin
          c_fin = 1'b1;
          c_exp.push_back(ref_fold(c_win, c_win.size() - 3, 2, 2, 2, 4, 1'b0));
        end
        if (c_win.size() == 4) c_win.delete();
      end
    end
  end

  task automatic ab_send(input logic [3:0] d);
    int guard;
    guard = 0;
    ab_vld = 1'b1;
    ab_dat = d;
    @(negedge clk);
    while (!a_in.tready && guard < 200) begin @(negedge clk); guard++; end
    if (guard >= 200) check_eq("ab_send_timeout", 64'(guard), 64'd0);
    @(posedge clk); #1;
    ab_vld = 1'b0;
  endtask

  task automatic c_send(input logic [7:0] d);
    int guard;
    guard = 0;
    c_vld = 1'b1;
    c_dat = d;
    @(negedge clk);
    while (!c_in.tready && guard < 200) begin @(negedge clk); guard++; end
    if (guard >= 200) check_eq("c_send_timeout", 64'(guard), 64'd0);
    @(posedge clk); #1;
    c_vld = 1'b0;
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, tests %0d", n_tests);
    $fatal(1, "watchdog expired");
  end

  initial begin
    ab_vld = 1'b0; ab_dat = 4'd0; a_rdy = 1'b1;
    c_vld = 1'b0;  c_dat = 8'd0;  c_rdy = 1'b1;
    rnd_done = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    do_reset(3);
    check_eq("rst_a_valid", 64'(a_out.tvalid), 64'd0);
    check_eq("rst_a_data", 64'(a_out.tdata), 64'd0);
    check_eq("rst_c_valid", 64'(c_out.tvalid), 64'd0);
    check_eq("rst_c_data", 64'(c_out.tdata), 64'd0);

    // Basic unsigned window, then the signed/unsigned contrast.
    ab_send(4'd3); ab_send(4'd9); ab_send(4'd1); ab_send(4'd7);
    check_eq("basic_valid", 64'(a_out.tvalid), 64'd1);
    check_eq("basic_max", 64'(a_out.tdata), 64'd9);
    ab_send(4'hF); ab_send(4'h2); ab_send(4'h8); ab_send(4'h1);
    check_eq("unsigned_max", 64'(a_out.tdata), 64'hF);
    check_eq("signed_max", 64'(b_out.tdata), 64'h2);

    // SIMD=2 with two folds: outputs appear in fold order.
    c_send(8'h51); c_send(8'h04); c_send(8'h23);
    check_eq("fold0_out", 64'(c_out.tdata), 64'h53);
    c_send(8'h62);
    check_eq("fold1_out", 64'(c_out.tdata), 64'h64);
    c_send(8'h00); c_send(8'h00); c_send(8'h00); c_send(8'h00);
    check_eq("fold_zero_window", 64'(c_out.tdata), 64'h00);

    // Back-pressure across two windows.
    repeat (2) @(posedge clk); #1;
    a_rdy = 1'b0;
    fork
      begin for (int i = 0; i < 8; i++) ab_send(4'($urandom)); end
      begin
        repeat (7) @(posedge clk);
        @(negedge clk);
        check_eq("bp_tready_low", 64'(a_in.tready), 64'd0);
        check_eq("bp_out_held", 64'(a_out.tvalid), 64'd1);
        @(posedge clk); #1;
        a_rdy = 1'b1;
      end
    join
    repeat (3) @(posedge clk); #1;

    // Reset mid-window drops the stale partial max.
    ab_send(4'hE); ab_send(4'hF);
    do_reset(2);
    ab_send(4'd2); ab_send(4'd2); ab_send(4'd2); ab_send(4'd8);
    check_eq("post_rst_max", 64'(a_out.tdata), 64'd8);
    @(posedge clk); #1;
`ifdef SWG_MAXPOOL_PERF_CNT_EN
    check_eq("post_rst_win_count", 64'(a_wc), 64'd1);
`endif

    // Random data, random gaps and random sink readiness on all instances.
    fork
      begin
        fork
          begin
            for (int i = 0; i < 160; i++) begin
              ab_send(4'($urandom));
              if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
            end
          end
          begin
            for (int j = 0; j < 120; j++) begin
              c_send(8'($urandom));
              if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
            end
          end
        join
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk); #1;
          a_rdy = 1'($urandom);
          c_rdy = 1'($urandom);
        end
      end
    join
    a_rdy = 1'b1; c_rdy = 1'b1;
    repeat (4) @(posedge clk); #1;

    // Throughput: 144 back-to-back windows with an always-ready sink.
    t0 = cyc;
    g0 = a_got;
    for (int i = 0; i < 576; i++) ab_send(4'($urandom));
    check_eq("tp_cycles", 64'(cyc - t0), 64'd576);
    @(posedge clk); #1;
    check_eq("tp_outputs", 64'(a_got - g0), 64'd144);

    repeat (3) @(posedge clk); #1;
    check_eq("a_drained", 64'(a_exp.size()), 64'd0);
    check_eq("b_drained", 64'(b_exp.size()), 64'd0);
    check_eq("c_drained", 64'(c_exp.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
